// File: rtl/crossbar_pkg.sv
// Shared types for the streaming crossbar: dest-width helper, per-source
// routing FSM states and the skid-buffer entry layout.
package crossbar_pkg;

   function automatic int dest_width(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

   localparam int CB_DATA_WIDTH = 8;
   localparam int CB_PORT_COUNT = 3;
   localparam int CB_DEST_WIDTH = dest_width(CB_PORT_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      ROUTE,
      DROP
   } route_state_t;

   // port is latched at the header and repeated on every beat of the packet
   typedef struct packed {
      logic [CB_DATA_WIDTH-1:0] data;
      logic                     last;
      logic                     dest_bad;
      logic [CB_DEST_WIDTH-1:0] port;
   } beat_entry_t;

endpackage

// File: rtl/stream_dest_router_if.sv
// Ingress stream plus arbiter request/grant and per-port egress handshake of
// one crossbar source.
interface stream_dest_router_if #(
   parameter int T_DATA_WIDTH = 8,
   parameter int M_DATA_COUNT = 3,
   parameter int T_DEST_WIDTH = crossbar_pkg::dest_width(M_DATA_COUNT)
);
   logic [T_DATA_WIDTH-1:0] s_data_i;
   logic                    s_last_i;
   logic [T_DEST_WIDTH-1:0] s_dest_i;
   logic                    s_valid_i;
   logic                    s_ready_o;
   logic [M_DATA_COUNT-1:0] req_o;
   logic [M_DATA_COUNT-1:0] grant_i;
   logic [T_DATA_WIDTH-1:0] m_data_o;
   logic                    m_last_o;
   logic [M_DATA_COUNT-1:0] m_valid_o;
   logic [M_DATA_COUNT-1:0] m_ready_i;

   modport slave (
      input  s_data_i, s_last_i, s_dest_i, s_valid_i, grant_i, m_ready_i,
      output s_ready_o, req_o, m_data_o, m_last_o, m_valid_o
   );

   modport master (
      output s_data_i, s_last_i, s_dest_i, s_valid_i, grant_i, m_ready_i,
      input  s_ready_o, req_o, m_data_o, m_last_o, m_valid_o
   );
endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry registered slice (head + spare); ready comes straight from a flop
// and the slice sustains one beat per cycle while the head keeps popping.
module stream_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_head,
   output logic             o_head_valid,
   input  logic             i_pop
);
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_spare;
   logic             r_headValid;
   logic             r_spareValid;
   logic             r_ready;
   logic             w_accept;
   logic             w_headFree;

   assign w_accept   = i_valid & r_ready;
   assign w_headFree = ~r_headValid | i_pop;

   // A full spare implies ready was low, so nothing is accepted in that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_head       <= '0;
         r_spare      <= '0;
         r_headValid  <= 1'b0;
         r_spareValid <= 1'b0;
         r_ready      <= 1'b0;
      end else if (w_headFree) begin
         if (r_spareValid) begin
            r_head      <= r_spare;
            r_headValid <= 1'b1;
         end else begin
            r_headValid <= w_accept;
            if (w_accept) begin
               r_head <= i_data;
            end
         end
         r_spareValid <= 1'b0;
         r_ready      <= 1'b1;
      end else begin
         if (w_accept) begin
            r_spare      <= i_data;
            r_spareValid <= 1'b1;
         end
         r_ready <= ~(r_spareValid | w_accept);
      end
   end

   assign o_ready      = r_ready;
   assign o_head       = r_head;
   assign o_head_valid = r_headValid;
endmodule

// File: rtl/stream_dest_router.sv
// Per-source crossbar ingress: latches the packet destination at the header,
// requests the chosen master-port arbiter and drops packets to absent ports.
module stream_dest_router
   import crossbar_pkg::*;
#(
   parameter int T_DATA_WIDTH   = CB_DATA_WIDTH,
   parameter int M_DATA_COUNT   = CB_PORT_COUNT,
   parameter int T_DEST_WIDTH   = dest_width(M_DATA_COUNT),
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   stream_dest_router_if.slave       io_bus,
   output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);
   logic                      r_hdr;
   logic [T_DEST_WIDTH-1:0]   r_pktPort;
   logic                      r_pktBad;
   logic [T_DEST_WIDTH-1:0]   r_routePort;
   logic [DROP_CNT_WIDTH-1:0] r_dropCnt;
   route_state_t              r_state;
   route_state_t              w_nextState;
   route_state_t              w_mode;
   beat_entry_t               w_inEntry;
   beat_entry_t               w_head;
   logic                      w_headValid;
   logic                      w_ready;
   logic                      w_accept;
   logic                      w_destBad;
   logic                      w_pop;
   logic                      w_dropDone;
   logic                      w_portGrant;
   logic                      w_portReady;
   logic [T_DEST_WIDTH-1:0]   w_port;
   logic [M_DATA_COUNT-1:0]   w_req;
   logic [M_DATA_COUNT-1:0]   w_valid;

   assign w_accept  = io_bus.s_valid_i & w_ready;
   assign w_destBad = (32'(io_bus.s_dest_i) >= M_DATA_COUNT);

   always_comb begin
      w_inEntry.data = io_bus.s_data_i;
      w_inEntry.last = io_bus.s_last_i;
      if (r_hdr) begin
         w_inEntry.port     = io_bus.s_dest_i;
         w_inEntry.dest_bad = w_destBad;
      end else begin
         w_inEntry.port     = r_pktPort;
         w_inEntry.dest_bad = r_pktBad;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hdr     <= 1'b1;
         r_pktPort <= '0;
         r_pktBad  <= 1'b0;
      end else if (w_accept) begin
         r_hdr <= io_bus.s_last_i;
         if (r_hdr) begin
            r_pktPort <= io_bus.s_dest_i;
            r_pktBad  <= w_destBad;
         end
      end
   end

   stream_skid_buffer #(
      .WIDTH($bits(beat_entry_t))
   ) u_skid (
      .clk          (clk),
      .rst          (rst),
      .i_data       (w_inEntry),
      .i_valid      (io_bus.s_valid_i),
      .o_ready      (w_ready),
      .o_head       (w_head),
      .o_head_valid (w_headValid),
      .i_pop        (w_pop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_routePort <= '0;
      end else begin
         r_state     <= w_nextState;
         r_routePort <= w_port;
      end
   end

   // A freshly filled head is routed in the same cycle, which keeps the
   // acceptance-to-valid latency at one cycle and avoids gaps between packets.
   always_comb begin
      w_mode = r_state;
      if (r_state == IDLE && w_headValid) begin
         w_mode = w_head.dest_bad ? DROP : ROUTE;
      end
      w_port      = (r_state == IDLE) ? w_head.port : r_routePort;
      w_portGrant = 1'b0;
      w_portReady = 1'b0;
      w_req       = '0;
      w_valid     = '0;
      w_pop       = 1'b0;
      w_dropDone  = 1'b0;
      w_nextState = w_mode;
      for (int j = 0; j < M_DATA_COUNT; j++) begin
         if (w_port == T_DEST_WIDTH'(j)) begin
            w_portGrant = io_bus.grant_i[j];
            w_portReady = io_bus.m_ready_i[j];
         end
      end
      case (w_mode)
         ROUTE: begin
            for (int j = 0; j < M_DATA_COUNT; j++) begin
               if (w_port == T_DEST_WIDTH'(j)) begin
                  w_req[j]   = 1'b1;
                  w_valid[j] = w_headValid & io_bus.grant_i[j];
               end
            end
            w_pop = w_headValid & w_portGrant & w_portReady;
            if (w_pop && w_head.last) begin
               w_nextState = IDLE;
            end
         end
         DROP: begin
            w_pop = w_headValid;
            if (w_pop && w_head.last) begin
               w_nextState = IDLE;
               w_dropDone  = 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dropCnt <= '0;
      end else if (w_dropDone && (r_dropCnt != '1)) begin
         r_dropCnt <= r_dropCnt + DROP_CNT_WIDTH'(1);
      end
   end

   assign io_bus.s_ready_o = w_ready;
   assign io_bus.req_o     = w_req;
   assign io_bus.m_valid_o = w_valid;
   assign io_bus.m_data_o  = (|w_valid) ? w_head.data : '0;
   assign io_bus.m_last_o  = (|w_valid) ? w_head.last : 1'b0;
   assign drop_cnt_o       = r_dropCnt;
endmodule

// File: doc/stream_dest_router.md
Name: stream_dest_router

Overview:
- Per-source ingress block of the streaming crossbar; it feeds the round-robin arbiters from the slave side.
- Accepts one valid/ready/last/dest stream and latches the destination on the first beat of each packet.
- Raises a request toward the selected master-port arbiter and presents beats only while that arbiter grants this source.
- Holds the route until the last beat and discards packets addressed to a nonexistent master port.

Parameters:
- T_DATA_WIDTH, 8, data width
- M_DATA_COUNT, 3, number of master ports
- T_DEST_WIDTH, $clog2(M_DATA_COUNT) (minimum 1), dest field width
- DROP_CNT_WIDTH, 8, width of the dropped-packet counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- s_data_i  in  T_DATA_WIDTH  input beat data
- s_last_i  in  1  last beat of packet
- s_dest_i  in  T_DEST_WIDTH  destination master port; sampled on header beat only
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input ready, driven directly from a flop
- req_o  out  M_DATA_COUNT  one-hot request to arbiter j
- grant_i  in  M_DATA_COUNT  grant from arbiter j to this source
- m_data_o  out  T_DATA_WIDTH  head beat data, shared across ports
- m_last_o  out  1  head beat last
- m_valid_o  out  M_DATA_COUNT  per-port valid
- m_ready_i  in  M_DATA_COUNT  per-port ready
- drop_cnt_o  out  DROP_CNT_WIDTH  saturating count of dropped packets

Behaviour:
- Input side is a 2-entry skid buffer (head, spare).
  - s_ready_o=1 iff spare entry is empty.
  - Full throughput: one beat per cycle when downstream stays ready.
  - Latency from input acceptance to m_valid_o is 1 cycle minimum.
- Each buffer entry stores {data, last, dest_bad, port}.
  - port is the dest latched at the header, carried on every beat of the packet.
- Header tracking: a hdr flag is set at reset and after any accepted beat with last=1; cleared after any accepted beat with last=0.
  - On a header beat, port=s_dest_i and dest_bad=(s_dest_i>=M_DATA_COUNT).
  - On non-header beats, s_dest_i is ignored.
- FSM state applies to the head entry. Reset state is IDLE.
  - IDLE: head empty. On head fill: dest_bad -> DROP, else -> ROUTE.
  - ROUTE:
    - req_o[port]=1.
    - m_valid_o[port]=grant_i[port].
    - A beat transfers on m_valid_o[port]&m_ready_i[port].
    - On transfer of a last beat: go to IDLE, or re-evaluate the next head in the same cycle if the spare is full.
  - DROP:
    - req_o=0, m_valid_o=0.
    - Head is popped every cycle.
    - On popping the last beat: drop_cnt_o increments (saturates at all-ones), then IDLE/next head as above.
- req_o stays asserted for the whole packet, including bubbles where the head is empty mid-packet. It deasserts the cycle after the last beat transfers, unless the next packet targets the same port.
- grant_i bits other than port are ignored. grant_i[port] low blocks transfer and holds the head; data is never lost.
- m_data_o and m_last_o show the head entry. They are don't-care when all m_valid_o=0 and are driven to 0 in that case.
- While m_valid_o[j]=1 and m_ready_i[j]=0, m_data_o and m_last_o are held stable.
- At most one m_valid_o bit is set. req_o is at most one-hot.
- Single-beat packet (header with last=1): valid header and tail in the same beat; handled without an extra cycle.
- Reset values: s_ready_o=0 during rst and 1 the first cycle after; req_o=0; m_valid_o=0; m_data_o=0; m_last_o=0; drop_cnt_o=0; buffer empty; hdr=1.
- Reset mid-packet: all buffered beats are discarded. The first beat after reset is a header.

Decomposition:
- Shared package crossbar_pkg holds:
  - the dest-width helper function (max(1, clog2))
  - FSM state enum {IDLE, ROUTE, DROP}
  - the buffer-entry struct
- One sub-module: stream_skid_buffer, the 2-entry registered slice, parameterised on payload width. It is reusable by the master-side egress.

Test Plan:
1. Reset then 3-beat packet, dest=2, grant_i=3'b100, m_ready_i=all ones -> req_o=3'b100 from cycle 1; m_valid_o[2] on 3 consecutive cycles with data A,B,C; m_last_o with C; req_o=0 the cycle after C.
2. Grant withheld: dest=1, grant_i=0 for 5 cycles then 3'b010 -> m_valid_o=0 while withheld; s_ready_o drops after 2 beats are buffered; beats then emerge in order, none lost.
3. Back-to-back packets to port 0 then port 2, each single-beat with last=1 -> req_o goes 3'b001 then 3'b100 on consecutive cycles; m_valid_o never has 2 bits set.
4. dest=3 with M_DATA_COUNT=3, 4-beat packet -> all 4 beats accepted; req_o=0 and m_valid_o=0 throughout; drop_cnt_o goes 0->1 after the last beat.
5. Backpressure stability: m_ready_i[1] toggles 1010… -> m_data_o/m_last_o stable while valid&!ready; full packet transferred intact.
6. rst asserted mid-packet after beat 2 of 5 -> outputs at reset values; the next beat is treated as a header using its own s_dest_i.
